// File: rtl/studio_pkg.sv
// Shared state/owner encodings and default memory map for the studio memory arbiter.
package studio_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] owner_t;

  localparam state_t S_CLEAR = 2'd0;
  localparam state_t S_LOAD  = 2'd1;
  localparam state_t S_RUN   = 2'd2;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_DMA  = 2'd1;
  localparam owner_t OWN_CPU  = 2'd2;

  localparam int unsigned STUDIO_ADDR_W    = 12;
  localparam int unsigned STUDIO_CART_BASE = 'h400;
  localparam int unsigned STUDIO_CART_SIZE = 1024;
  localparam int unsigned STUDIO_ROM_END   = 'h800;
  localparam int unsigned STUDIO_RAM_BASE  = 'h800;
  localparam int unsigned STUDIO_RAM_SIZE  = 512;
  localparam int unsigned STUDIO_DL_INDEX  = 1;

endpackage

// File: rtl/studio_mem_arbiter.sv
// Single-port memory arbiter: cartridge download, video DMA and CPU share one byte memory.
// Define STUDIO_RAM_CLEAR_EN to zero RAM after reset before the CPU is released.
module studio_mem_arbiter
  import studio_pkg::*;
#(
  parameter int unsigned ADDR_W    = STUDIO_ADDR_W,
  parameter int unsigned CART_BASE = STUDIO_CART_BASE,
  parameter int unsigned CART_SIZE = STUDIO_CART_SIZE,
  parameter int unsigned ROM_END   = STUDIO_ROM_END,
  parameter int unsigned RAM_BASE  = STUDIO_RAM_BASE,
  parameter int unsigned RAM_SIZE  = STUDIO_RAM_SIZE,
  parameter int unsigned DL_INDEX  = STUDIO_DL_INDEX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_wait,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  if ((CART_BASE + CART_SIZE > (1 << ADDR_W)) || (RAM_BASE + RAM_SIZE > (1 << ADDR_W))) begin
    : g_cfg_check
    $error("studio_mem_arbiter: cartridge or RAM window exceeds the address space");
  end

  state_t state_q, state_d;
  owner_t own_q, own_d;
  logic [7:0] dma_hold_q, cpu_hold_q;
  logic load_req;
  logic unused_idx;

  // Only the low six index bits select the target; the top bits are file-type flags.
  assign load_req   = ioctl_download && (ioctl_index[5:0] == 6'(DL_INDEX));
  assign unused_idx = ^ioctl_index[7:6];

`ifdef STUDIO_RAM_CLEAR_EN
  localparam int unsigned CntW = $clog2(RAM_SIZE + 1);
  localparam state_t ResetState = S_CLEAR;

  logic [CntW-1:0] clr_cnt_q, clr_cnt_d;
  logic clr_last, clr_pending;

  assign clr_last    = (clr_cnt_q == CntW'(RAM_SIZE - 1));
  assign clr_pending = (clr_cnt_q != CntW'(RAM_SIZE));
`else
  localparam state_t ResetState = S_RUN;
`endif

  always_comb begin
    state_d = state_q;
`ifdef STUDIO_RAM_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (!ioctl_download) begin
`ifdef STUDIO_RAM_CLEAR_EN
          state_d = clr_pending ? S_CLEAR : S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
`ifdef STUDIO_RAM_CLEAR_EN
      // A load pauses the clear; the pointer holds so the clear resumes where it stopped.
      S_CLEAR: begin
        if (load_req) begin
          state_d = S_LOAD;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_last) state_d = S_RUN;
        end
      end
`endif
      default: begin
        if (load_req) state_d = S_LOAD;
      end
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    dma_gnt   = 1'b0;
    cpu_wait  = 1'b0;
    busy      = 1'b0;
    own_d     = OWN_NONE;
    unique case (state_q)
      S_LOAD: begin
        busy     = 1'b1;
        cpu_wait = cpu_req;
        if (ioctl_wr && (32'(ioctl_addr) < CART_SIZE)) begin
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(CART_BASE) + ioctl_addr[ADDR_W-1:0];
          mem_wdata = ioctl_dout;
        end
      end
`ifdef STUDIO_RAM_CLEAR_EN
      S_CLEAR: begin
        busy     = 1'b1;
        cpu_wait = cpu_req;
        mem_we   = 1'b1;
        mem_addr = ADDR_W'(RAM_BASE) + ADDR_W'(clr_cnt_q);
      end
`endif
      default: begin
        if (dma_req) begin
          dma_gnt  = 1'b1;
          cpu_wait = cpu_req;
          mem_addr = dma_addr;
          own_d    = OWN_DMA;
        end else if (cpu_req) begin
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          // ROM writes are accepted and silently discarded.
          mem_we    = cpu_we && (32'(cpu_addr) >= ROM_END);
          if (!cpu_we) own_d = OWN_CPU;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ResetState;
      own_q      <= OWN_NONE;
      dma_hold_q <= 8'h00;
      cpu_hold_q <= 8'h00;
`ifdef STUDIO_RAM_CLEAR_EN
      clr_cnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      if (own_q == OWN_DMA) dma_hold_q <= mem_rdata;
      if (own_q == OWN_CPU) cpu_hold_q <= mem_rdata;
`ifdef STUDIO_RAM_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // Memory data arrives one cycle after the grant, alongside the registered valid.
  assign dma_rvalid = (own_q == OWN_DMA);
  assign cpu_rvalid = (own_q == OWN_CPU);
  assign dma_rdata  = dma_rvalid ? mem_rdata : dma_hold_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_q;

endmodule
